// File: rtl/dct2_1d_pipe.sv
// dct2_1d_pipe: three-stage handshaked 1-D DCT-II, 4/8/16/32 points per vector.
// S0 captures the masked input. S1 runs the shared butterfly cascade
// (32 -> 16 -> 8 -> 4) and registers natural-order 27-bit accumulators.
// S2 rounds, shifts and reduces to OUT_W.
// Optional feature: define DCT2_1D_SAT_EN for clamping with the out_sat flag.
// Without it the shifted value wraps to OUT_W bits and out_sat is tied low.

module dct2_1d_pipe #(
  parameter int SHIFT = 11,
  parameter int OUT_W = 16,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_size,
  input  logic [511:0]         in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_size,
  output logic [32*OUT_W-1:0]  out_data,
  output logic                 out_last,
  output logic                 out_sat
);

  localparam int LANES = 32;
  localparam int IN_W  = 16;
  localparam int ACC_W = 27;
  localparam logic signed [31:0] RND_OFF =
    (ROUND != 0) ? (32'sd1 <<< (SHIFT - 1)) : 32'sd0;
`ifdef DCT2_1D_SAT_EN
  localparam logic signed [31:0] SAT_MAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
  localparam logic signed [31:0] SAT_MIN = -(32'sd1 <<< (OUT_W - 1));
`endif

  // Number of active lanes for a size code.
  function automatic int size_lanes(input logic [1:0] sz);
    int n;
    case (sz)
      2'b00:   n = 4;
      2'b01:   n = 8;
      2'b10:   n = 16;
      2'b11:   n = 32;
      default: n = 32;
    endcase
    return n;
  endfunction

  // Integer cosine magnitude for angle a*pi/64, a in 1..31.
  function automatic logic signed [ACC_W-1:0] cos_mag(input int a);
    logic signed [ACC_W-1:0] c;
    case (a)
      32'sd1:  c = 27'sd90;  32'sd2:  c = 27'sd90;  32'sd3:  c = 27'sd90;
      32'sd4:  c = 27'sd89;  32'sd5:  c = 27'sd88;  32'sd6:  c = 27'sd87;
      32'sd7:  c = 27'sd85;  32'sd8:  c = 27'sd83;  32'sd9:  c = 27'sd82;
      32'sd10: c = 27'sd80;  32'sd11: c = 27'sd78;  32'sd12: c = 27'sd75;
      32'sd13: c = 27'sd73;  32'sd14: c = 27'sd70;  32'sd15: c = 27'sd67;
      32'sd16: c = 27'sd64;  32'sd17: c = 27'sd61;  32'sd18: c = 27'sd57;
      32'sd19: c = 27'sd54;  32'sd20: c = 27'sd50;  32'sd21: c = 27'sd46;
      32'sd22: c = 27'sd43;  32'sd23: c = 27'sd38;  32'sd24: c = 27'sd36;
      32'sd25: c = 27'sd31;  32'sd26: c = 27'sd25;  32'sd27: c = 27'sd22;
      32'sd28: c = 27'sd18;  32'sd29: c = 27'sd13;  32'sd30: c = 27'sd9;
      32'sd31: c = 27'sd4;
      default: c = 27'sd0;
    endcase
    return c;
  endfunction

  // Signed integer cosine for angle idx*pi/64 (any non-negative idx).
  function automatic logic signed [ACC_W-1:0] dct_coef(input int idx);
    int a;
    logic signed [ACC_W-1:0] c;
    a = idx % 128;
    if (a > 64) begin
      a = 128 - a;
    end else begin
      a = a;
    end
    if (a == 32) begin
      c = 27'sd0;
    end else if (a > 32) begin
      c = -cos_mag(64 - a);
    end else begin
      c = cos_mag(a);
    end
    return c;
  endfunction

  // Pipeline state
  logic         v0_q, v1_q, v2_q;
  logic         en0, en1, en2;
  logic [511:0] s0_data_q, s0_data_d;
  logic [1:0]   s0_size_q, s1_size_q, s2_size_q;
  logic         s0_last_q, s1_last_q, s2_last_q;
  logic signed [ACC_W-1:0] s1_acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d    [LANES];
  logic [32*OUT_W-1:0] s2_data_q, s2_data_d;
  logic         s2_sat_d;

  // Cascade intermediates
  logic signed [ACC_W-1:0] x    [LANES];
  logic signed [ACC_W-1:0] e32  [16];
  logic signed [ACC_W-1:0] o32  [16];
  logic signed [ACC_W-1:0] in16 [16];
  logic signed [ACC_W-1:0] e16  [8];
  logic signed [ACC_W-1:0] o16  [8];
  logic signed [ACC_W-1:0] in8  [8];
  logic signed [ACC_W-1:0] e8   [4];
  logic signed [ACC_W-1:0] o8   [4];
  logic signed [ACC_W-1:0] in4  [4];
  logic signed [ACC_W-1:0] e4   [2];
  logic signed [ACC_W-1:0] o4   [2];
  logic signed [ACC_W-1:0] y4   [4];
  logic signed [ACC_W-1:0] y8   [8];
  logic signed [ACC_W-1:0] y16  [16];
  logic signed [ACC_W-1:0] y32  [32];

  // Scale intermediates
  logic signed [31:0] lane_wide  [LANES];
  logic signed [31:0] lane_shift [LANES];

  // Stage enables: a stage may load when it is empty or its content moves on.
  always_comb begin
    en2 = !v2_q || out_ready;
    en1 = !v1_q || en2;
    en0 = !v0_q || en1;
  end

  assign in_ready  = en0;
  assign out_valid = v2_q;
  assign out_size  = s2_size_q;
  assign out_data  = s2_data_q;
  assign out_last  = s2_last_q;

  // Zero the lanes beyond the requested size before capture.
  always_comb begin
    s0_data_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < size_lanes(in_size)) begin
        s0_data_d[i*IN_W +: IN_W] = in_data[i*IN_W +: IN_W];
      end else begin
        s0_data_d[i*IN_W +: IN_W] = 16'd0;
      end
    end
  end

  // S0 input register: loads on input handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q      <= 1'b0;
      s0_data_q <= '0;
      s0_size_q <= 2'b00;
      s0_last_q <= 1'b0;
    end else if (en0) begin
      v0_q <= in_valid;
      if (in_valid) begin
        s0_data_q <= s0_data_d;
        s0_size_q <= in_size;
        s0_last_q <= in_last;
      end
    end
  end

  // Butterfly cascade: each level takes raw samples at its own size,
  // otherwise the even half of the level above.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x[i] = ACC_W'(signed'(s0_data_q[i*IN_W +: IN_W]));
    end
    for (int n = 0; n < 16; n++) begin
      e32[n]  = x[n] + x[31-n];
      o32[n]  = x[n] - x[31-n];
      in16[n] = (s0_size_q == 2'b10) ? x[n] : e32[n];
    end
    for (int n = 0; n < 8; n++) begin
      e16[n] = in16[n] + in16[15-n];
      o16[n] = in16[n] - in16[15-n];
      in8[n] = (s0_size_q == 2'b01) ? x[n] : e16[n];
    end
    for (int n = 0; n < 4; n++) begin
      e8[n]  = in8[n] + in8[7-n];
      o8[n]  = in8[n] - in8[7-n];
      in4[n] = (s0_size_q == 2'b00) ? x[n] : e8[n];
    end
    for (int n = 0; n < 2; n++) begin
      e4[n] = in4[n] + in4[3-n];
      o4[n] = in4[n] - in4[3-n];
    end

    // 4-point core
    y4[0] = 27'sd64 * (e4[0] + e4[1]);
    y4[2] = 27'sd64 * (e4[0] - e4[1]);
    for (int k = 1; k < 4; k += 2) begin
      y4[k] = 27'sd0;
      for (int n = 0; n < 2; n++) begin
        y4[k] = y4[k] + o4[n] * dct_coef(8 * k * (2 * n + 1));
      end
    end

    // Each wider level: even outputs from the level below, odd from its own differences.
    for (int m = 0; m < 4; m++) begin
      y8[2*m] = y4[m];
    end
    for (int k = 1; k < 8; k += 2) begin
      y8[k] = 27'sd0;
      for (int n = 0; n < 4; n++) begin
        y8[k] = y8[k] + o8[n] * dct_coef(4 * k * (2 * n + 1));
      end
    end
    for (int m = 0; m < 8; m++) begin
      y16[2*m] = y8[m];
    end
    for (int k = 1; k < 16; k += 2) begin
      y16[k] = 27'sd0;
      for (int n = 0; n < 8; n++) begin
        y16[k] = y16[k] + o16[n] * dct_coef(2 * k * (2 * n + 1));
      end
    end
    for (int m = 0; m < 16; m++) begin
      y32[2*m] = y16[m];
    end
    for (int k = 1; k < 32; k += 2) begin
      y32[k] = 27'sd0;
      for (int n = 0; n < 16; n++) begin
        y32[k] = y32[k] + o32[n] * dct_coef(k * (2 * n + 1));
      end
    end

    // Natural-order selection; unused lanes stay zero.
    for (int k = 0; k < LANES; k++) begin
      acc_d[k] = 27'sd0;
    end
    case (s0_size_q)
      2'b00: for (int k = 0; k < 4; k++)  acc_d[k] = y4[k];
      2'b01: for (int k = 0; k < 8; k++)  acc_d[k] = y8[k];
      2'b10: for (int k = 0; k < 16; k++) acc_d[k] = y16[k];
      2'b11: for (int k = 0; k < 32; k++) acc_d[k] = y32[k];
      default: for (int k = 0; k < LANES; k++) acc_d[k] = 27'sd0;
    endcase
  end

  // S1 core register: holds the natural-order accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q      <= 1'b0;
      s1_size_q <= 2'b00;
      s1_last_q <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_acc_q[k] <= 27'sd0;
      end
    end else if (en1) begin
      v1_q <= v0_q;
      if (v0_q) begin
        s1_size_q <= s0_size_q;
        s1_last_q <= s0_last_q;
        for (int k = 0; k < LANES; k++) begin
          s1_acc_q[k] <= acc_d[k];
        end
      end
    end
  end

  // Round, shift and reduce every lane to OUT_W.
  always_comb begin
    s2_data_d = '0;
    s2_sat_d  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_wide[k]  = 32'(s1_acc_q[k]) + RND_OFF;
      lane_shift[k] = lane_wide[k] >>> SHIFT;
      if (k < size_lanes(s1_size_q)) begin
`ifdef DCT2_1D_SAT_EN
        if (lane_shift[k] > SAT_MAX) begin
          s2_data_d[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
          s2_sat_d = 1'b1;
        end else if (lane_shift[k] < SAT_MIN) begin
          s2_data_d[k*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
          s2_sat_d = 1'b1;
        end else begin
          s2_data_d[k*OUT_W +: OUT_W] = lane_shift[k][OUT_W-1:0];
        end
`else
        s2_data_d[k*OUT_W +: OUT_W] = lane_shift[k][OUT_W-1:0];
`endif
      end else begin
        s2_data_d[k*OUT_W +: OUT_W] = '0;
      end
    end
  end

`ifdef DCT2_1D_SAT_EN
  logic s2_sat_q;
  // Saturation flag travels with the S2 result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sat_q <= 1'b0;
    end else if (en2 && v1_q) begin
      s2_sat_q <= s2_sat_d;
    end
  end
  assign out_sat = s2_sat_q;
`else
  assign out_sat = 1'b0;
`endif

  // S2 output register: holds steady while out_valid and not out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q      <= 1'b0;
      s2_data_q <= '0;
      s2_size_q <= 2'b00;
      s2_last_q <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        s2_data_q <= s2_data_d;
        s2_size_q <= s1_size_q;
        s2_last_q <= s1_last_q;
      end
    end
  end

endmodule

// File: doc/dct2_1d_pipe.md
# dct2_1d_pipe

Pipelined, handshaked successor to the combinational 1-D DCT-II top level. It accepts one vector of up to 32 signed 16-bit samples per transaction, with transform size 4/8/16/32 selected per transaction. The vector runs through the existing dct2_32/dct2_16/dct2_8/dct2_4 butterfly cascade. Results come out in natural frequency order with a parametrised rounding shift and output width. The block sits between the row/column buffer and the transpose memory, and supports full-rate streaming with backpressure.

## Interface
Parameters:
- SHIFT, 11, right shift applied to the 27-bit core accumulators; legal range 1..11.
- OUT_W, 16, output coefficient width; legal range 8..16.
- ROUND, 1, 1 = add 1<<(SHIFT-1) before shifting (round half up); 0 = truncate.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_size  in  2  transform size: 00=4, 01=8, 10=16, 11=32.
- in_data  in  512  32 lanes × 16-bit signed; lane i at bits [i*16 +: 16].
- in_last  in  1  sideband flag, passed through unchanged.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts.
- out_size  out  2  size of the transaction being presented.
- out_data  out  32*OUT_W  coefficient k at [k*OUT_W +: OUT_W]; lanes k ≥ size are zero.
- out_last  out  1  in_last of the same transaction.
- out_sat  out  1  any coefficient clipped (only with the macro; otherwise tied 0).

## Operation
- Stage S0, input register: captures in_data, in_size and in_last on input handshake. Lanes ≥ size are forced to zero at capture.
- Stage S1, core register: sign-extends S0 lanes and feeds them into the cascade.
  - Size muxes: the 16-point input is the raw samples when size=10, else the 32-point even output. The 8-point and 4-point inputs follow the same rule.
  - Registers 32 × 27-bit accumulators, permuted to natural order k = 0..size-1.
- Stage S2, scale register: per lane, optionally adds the rounding offset, arithmetically shifts right by SHIFT, then reduces to OUT_W (see Configuration). Registers the result.
- Each stage holds a valid bit. A stage advances when its downstream stage is empty or advancing in the same cycle.
- in_ready = !v0 | advance0. This is a combinational path from out_ready, which is accepted.
- Handshakes:
  - Input handshake: in_valid & in_ready. Output handshake: out_valid & out_ready.
  - out_data, out_size, out_last and out_sat stay stable while out_valid & !out_ready.
- in_size is sampled only at input handshake. Mixed sizes in consecutive vectors are legal and do not interact.

## Timing
- Latency: an input handshake in cycle t gives out_valid in cycle t+3 when there is no stall.
- Throughput: one vector per cycle while out_ready stays high.
- Stall: out_ready low with all three stages full drops in_ready in the same cycle. When out_ready returns, in_ready rises in that same cycle.
- Reset values: out_valid=0, in_ready=1 (the cycle after rst deasserts), out_data=0, out_size=00, out_last=0, out_sat=0, all stage valids 0.
- Reset mid-operation: all in-flight vectors are discarded and no partial output appears. rst has priority over simultaneous handshakes.
- Simultaneous output handshake and input handshake with a full pipe: the pipe shifts and stays full, and no vector is lost or duplicated.

## Configuration
- DCT2_1D_SAT_EN defined:
  - Shifted values beyond the OUT_W signed range clamp to +2^(OUT_W-1)-1 or -2^(OUT_W-1).
  - out_sat=1 for any transaction in which at least one lane clamped.
- Undefined: the shifted value is truncated to its low OUT_W bits (wrap). out_sat is constant 0.

## Test plan
- Size 11, all lanes 1000, SHIFT=11, ROUND=1 -> out_data[0]=1000, lanes 1..31 = 0, out_valid 3 cycles after accept.
- Size 00, lane0=20, others 0, SHIFT=11:
  - ROUND=1 -> Y = {1, 1, 1, 0}.
  - ROUND=0 -> Y = {0, 0, 0, 0}.
  - In both cases lanes 4..31 = 0.
- Size 11, all lanes 32767, SHIFT=10, DCT2_1D_SAT_EN defined -> Y0=32767, out_sat=1. Same stimulus with SHIFT=11 -> Y0=32767, out_sat=0.
- Size 11, all lanes -32768, SHIFT=11 -> Y0=-32768, others 0, out_sat=0.
- Back-to-back sizes 00, 01, 10, 11 streamed with out_ready held low for 5 cycles mid-stream:
  - in_ready drops once 3 vectors are held.
  - Outputs appear in order with the correct out_size and out_last.
  - Nothing is lost or duplicated.
- rst pulsed with 2 vectors in flight -> next cycle out_valid=0, out_data=0, and no stale output after release.
